// File: rtl/spi_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spi_arb_pkg
// Brief    : Shared types and constants for the SPI client arbiter.
// Revision : 1.0
// ============================================================================
package spi_arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_BUSY  = 2'd2,
        S_GAP   = 2'd3
    } state_t;

    localparam int REQ_A2D   = 0;
    localparam int REQ_INERT = 1;
    localparam int NREQ      = 2;
    localparam int CMD_W     = 16;

endpackage
`default_nettype wire

// File: rtl/spi_arb_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module   : rr_arb2
// Brief    : Combinational 2-way round-robin picker; last = index served last.
// Revision : 1.0
// ============================================================================
module rr_arb2
    import spi_arb_pkg::*;
(
    input  logic [NREQ-1:0] req,
    input  logic            last,
    output logic [NREQ-1:0] win,
    output logic            valid
);

    always_comb begin
        win   = '0;
        valid = |req;
        case (req)
            2'b01:   win = 2'b01;
            2'b10:   win = 2'b10;
            // On a tie, the requester not served last goes first.
            2'b11:   win = last ? 2'b01 : 2'b10;
            default: win = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/spi_arb.sv
`default_nettype none
// ============================================================================
// Module   : spi_arb
// Brief    : Round-robin sharing of one SPI master between A2D and inertial.
// Revision : 1.0
// ============================================================================
module spi_arb
    import spi_arb_pkg::*;
#(
    parameter int GAP     = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [CMD_W-1:0]  cmd0,
    input  logic [CMD_W-1:0]  cmd1,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   done,
    output logic              err,
    output logic [CMD_W-1:0]  rd_data,
    output logic              spi_wrt,
    output logic [CMD_W-1:0]  spi_cmd,
    input  logic              spi_done,
    input  logic [CMD_W-1:0]  spi_rd_data,
    input  logic              spi_ss_n,
    output logic [NREQ-1:0]   ss_n
);

    localparam logic [11:0] C_TMO_LAST = 12'(TIMEOUT - 1);
    localparam logic [3:0]  C_GAP_LAST = 4'(GAP - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [NREQ-1:0]     r_gnt;
    logic                r_idx;
    logic                r_ptr;
    logic [NREQ-1:0]     r_done;
    logic                r_err;
    logic [CMD_W-1:0]    r_rd_data;
    logic                r_spi_wrt;
    logic [CMD_W-1:0]    r_spi_cmd;
    logic [11:0]         r_tcnt;
    logic [3:0]          r_gcnt;
    logic [NREQ-1:0]     w_win;
    logic                w_valid;
    logic                w_tmo;

    rr_arb2 u_rr (
        .req   (req),
        .last  (r_ptr),
        .win   (w_win),
        .valid (w_valid)
    );

    assign w_tmo = (r_tcnt == C_TMO_LAST);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_valid) w_state_nxt = S_ISSUE;
            S_ISSUE: w_state_nxt = S_BUSY;
            S_BUSY:  if (spi_done || w_tmo) w_state_nxt = S_GAP;
            S_GAP:   if (r_gcnt == C_GAP_LAST) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_gnt     <= '0;
            r_idx     <= 1'b0;
            r_ptr     <= 1'b1;
            r_done    <= '0;
            r_err     <= 1'b0;
            r_rd_data <= '0;
            r_spi_wrt <= 1'b0;
            r_spi_cmd <= '0;
            r_tcnt    <= '0;
            r_gcnt    <= '0;
        end else begin
            r_spi_wrt <= 1'b0;
            r_done    <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_valid) begin
                        r_gnt     <= w_win;
                        r_idx     <= w_win[REQ_INERT];
                        r_spi_cmd <= w_win[REQ_INERT] ? cmd1 : cmd0;
                    end
                end
                S_ISSUE: begin
                    r_spi_wrt <= 1'b1;
                    r_tcnt    <= '0;
                end
                S_BUSY: begin
                    if (r_tcnt != '1) r_tcnt <= r_tcnt + 12'd1;
                    // A real completion beats a simultaneous timeout.
                    if (spi_done) begin
                        r_rd_data <= spi_rd_data;
                        r_err     <= 1'b0;
                        r_done    <= r_gnt;
                        r_ptr     <= r_idx;
                        r_gcnt    <= '0;
                    end else if (w_tmo) begin
                        r_rd_data <= '0;
                        r_err     <= 1'b1;
                        r_done    <= r_gnt;
                        r_ptr     <= r_idx;
                        r_gcnt    <= '0;
                    end
                end
                S_GAP: begin
                    r_gnt <= '0;
                    if (r_gcnt != '1) r_gcnt <= r_gcnt + 4'd1;
                end
                default: r_gnt <= '0;
            endcase
        end
    end

    always_comb begin
        ss_n = '1;
        if (|r_gnt) ss_n[r_idx] = spi_ss_n;
    end

    assign gnt     = r_gnt;
    assign done    = r_done;
    assign err     = r_err;
    assign rd_data = r_rd_data;
    assign spi_wrt = r_spi_wrt;
    assign spi_cmd = r_spi_cmd;

endmodule
`default_nettype wire
